// File: rtl/bht_pkg.sv
//------------------------------------------------------------------------------
// Module   : bht_pkg
// Brief    : Shared defaults, counter encodings and sequencing states for the
//            BHT port arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bht_pkg;

    localparam int DEF_IDX_W      = 6;
    localparam int DEF_QDEPTH     = 4;
    localparam int DEF_STARVE_MAX = 8;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/bht_upd_fifo.sv
//------------------------------------------------------------------------------
// Module   : bht_upd_fifo
// Brief    : Circular queue of pending BHT updates; all slots are exposed so the
//            arbiter can bypass queued values to lookups.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bht_upd_fifo #(
    parameter int IDX_W  = 6,
    parameter int QDEPTH = 4,
    localparam int PTR_W = $clog2(QDEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [IDX_W-1:0]             push_idx_i,
    input  logic [1:0]                   push_cnt_i,
    input  logic                         pop_i,
    output logic [CNT_W-1:0]             count_o,
    output logic [PTR_W-1:0]             rd_ptr_o,
    output logic [QDEPTH-1:0][IDX_W-1:0] ent_idx_o,
    output logic [QDEPTH-1:0][1:0]       ent_cnt_o,
    output logic [IDX_W-1:0]             head_idx_o,
    output logic [1:0]                   head_cnt_o
);

    logic [PTR_W-1:0]             wr_ptr_q;
    logic [PTR_W-1:0]             rd_ptr_q;
    logic [CNT_W-1:0]             count_q;
    logic [QDEPTH-1:0][IDX_W-1:0] idx_q;
    logic [QDEPTH-1:0][1:0]       cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Payload needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_i) begin
            idx_q[wr_ptr_q] <= push_idx_i;
            cnt_q[wr_ptr_q] <= push_cnt_i;
        end
    end

    assign count_o    = count_q;
    assign rd_ptr_o   = rd_ptr_q;
    assign ent_idx_o  = idx_q;
    assign ent_cnt_o  = cnt_q;
    assign head_idx_o = idx_q[rd_ptr_q];
    assign head_cnt_o = cnt_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/bht_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : bht_port_arbiter
// Brief    : Shares one single-port BHT SRAM between fetch lookups and queued
//            counter updates, after an initial sweep writing WNT everywhere.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bht_port_arbiter
    import bht_pkg::*;
#(
    parameter int IDX_W      = DEF_IDX_W,
    parameter int QDEPTH     = DEF_QDEPTH,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lookup_req,
    input  logic [IDX_W-1:0]           lookup_idx,
    output logic                       lookup_gnt,
    output logic                       lookup_valid,
    output logic [1:0]                 lookup_cnt,
    input  logic                       upd_req,
    input  logic [IDX_W-1:0]           upd_idx,
    input  logic [1:0]                 upd_cnt,
    output logic                       upd_ready,
    output logic                       bht_en,
    output logic                       bht_we,
    output logic [IDX_W-1:0]           bht_addr,
    output logic [1:0]                 bht_wdata,
    input  logic [1:0]                 bht_rdata,
    output logic                       init_done,
    output logic [$clog2(QDEPTH):0]    q_count
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);

    localparam logic [0:0]       S_INIT   = INIT;
    localparam logic [0:0]       S_RUN    = RUN;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             valid_q;
    logic             hit_q, hit_d;
    logic [1:0]       hit_cnt_q, hit_cnt_d;

    logic                         w_run, w_init_wr, w_full, w_empty;
    logic                         w_force_drain, w_gnt, w_drain, w_enq;
    logic [PTR_W-1:0]             w_rd_ptr;
    logic [QDEPTH-1:0][IDX_W-1:0] w_ent_idx;
    logic [QDEPTH-1:0][1:0]       w_ent_cnt;
    logic [IDX_W-1:0]             w_head_idx;
    logic [1:0]                   w_head_cnt;

    bht_upd_fifo #(
        .IDX_W  (IDX_W),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (w_enq),
        .push_idx_i (upd_idx),
        .push_cnt_i (upd_cnt),
        .pop_i      (w_drain),
        .count_o    (q_count),
        .rd_ptr_o   (w_rd_ptr),
        .ent_idx_o  (w_ent_idx),
        .ent_cnt_o  (w_ent_cnt),
        .head_idx_o (w_head_idx),
        .head_cnt_o (w_head_cnt)
    );

    // Gating with rst keeps every output low while reset is held.
    assign w_run         = rst && (state_q == S_RUN);
    assign w_init_wr     = rst && (state_q == S_INIT);
    assign w_full        = (q_count == CNT_W'(QDEPTH));
    assign w_empty       = (q_count == '0);
    assign w_force_drain = w_full || (starve_q == SW'(STARVE_MAX));
    assign w_gnt         = w_run && lookup_req && !w_force_drain;
    assign w_drain       = w_run && !w_empty && !w_gnt;
    assign upd_ready     = w_run && !w_full;
    assign w_enq         = upd_req && upd_ready;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == S_INIT) begin
            sweep_d = sweep_q + IDX_W'(1);
            if (sweep_q == LAST_IDX) state_d = S_RUN;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (w_drain || w_empty) starve_d = '0;
        else if (w_gnt)         starve_d = starve_q + SW'(1);
    end

    // Walk oldest to youngest so the youngest match wins; a same-cycle enqueue is youngest of all.
    always_comb begin
        hit_d     = 1'b0;
        hit_cnt_d = SNT;
        for (int i = 0; i < QDEPTH; i++) begin
            if ((CNT_W'(i) < q_count) && (w_ent_idx[w_rd_ptr + PTR_W'(i)] == lookup_idx)) begin
                hit_d     = 1'b1;
                hit_cnt_d = w_ent_cnt[w_rd_ptr + PTR_W'(i)];
            end
        end
        if (w_enq && (upd_idx == lookup_idx)) begin
            hit_d     = 1'b1;
            hit_cnt_d = upd_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_INIT;
            sweep_q   <= '0;
            starve_q  <= '0;
            valid_q   <= 1'b0;
            hit_q     <= 1'b0;
            hit_cnt_q <= SNT;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            starve_q <= starve_d;
            valid_q  <= w_gnt;
            if (w_gnt) begin
                hit_q     <= hit_d;
                hit_cnt_q <= hit_cnt_d;
            end
        end
    end

    assign lookup_gnt   = w_gnt;
    assign lookup_valid = valid_q;
    assign lookup_cnt   = !valid_q ? SNT : (hit_q ? hit_cnt_q : bht_rdata);
    assign init_done    = w_run;

    assign bht_en    = w_init_wr || w_gnt || w_drain;
    assign bht_we    = w_init_wr || w_drain;
    assign bht_addr  = w_init_wr ? sweep_q : (w_drain ? w_head_idx : (w_gnt ? lookup_idx : '0));
    assign bht_wdata = w_init_wr ? WNT : (w_drain ? w_head_cnt : SNT);

endmodule

`default_nettype wire

// File: tb/tb_bht_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_bht_port_arbiter
// Brief    : Self-checking bench for bht_port_arbiter with an SRAM model and a
//            lookup/drain scoreboard.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_bht_port_arbiter;

    localparam int IDX_W      = 6;
    localparam int QDEPTH     = 4;
    localparam int STARVE_MAX = 8;
    localparam int CNT_W      = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lookup_req, lookup_gnt, lookup_valid;
    logic [IDX_W-1:0] lookup_idx;
    logic [1:0]       lookup_cnt;
    logic             upd_req, upd_ready;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_cnt;
    logic             bht_en, bht_we, init_done;
    logic [IDX_W-1:0] bht_addr;
    logic [1:0]       bht_wdata, bht_rdata;
    logic [CNT_W-1:0] q_count;

    always #5 clk = ~clk;

    bht_port_arbiter #(
        .IDX_W      (IDX_W),
        .QDEPTH     (QDEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_req   (lookup_req),
        .lookup_idx   (lookup_idx),
        .lookup_gnt   (lookup_gnt),
        .lookup_valid (lookup_valid),
        .lookup_cnt   (lookup_cnt),
        .upd_req      (upd_req),
        .upd_idx      (upd_idx),
        .upd_cnt      (upd_cnt),
        .upd_ready    (upd_ready),
        .bht_en       (bht_en),
        .bht_we       (bht_we),
        .bht_addr     (bht_addr),
        .bht_wdata    (bht_wdata),
        .bht_rdata    (bht_rdata),
        .init_done    (init_done),
        .q_count      (q_count)
    );

    // Single-port SRAM with one-cycle read latency and a backdoor write.
    logic [1:0]       mem [0:63];
    logic             bd_en = 1'b0;
    logic [IDX_W-1:0] bd_addr = '0;
    logic [1:0]       bd_data = 2'b00;

    always @(posedge clk) begin
        if (bht_en && bht_we)  mem[bht_addr] <= bht_wdata;
        else if (bht_en)       bht_rdata <= mem[bht_addr];
        if (bd_en)             mem[bd_addr] <= bd_data;
    end

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [1:0]       cnt;
    } upd_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] arch [0:63];
    upd_t       upd_q[$];
    logic [1:0] exp_q[$];
    int         mq  = 0;
    int         mst = 0;
    bit         prev_gnt = 1'b0;
    bit         mon_en   = 1'b0;

    // Reference model of arbitration and scoreboard of lookup results / drain order.
    always @(negedge clk) begin
        if (mon_en) begin
            bit         eg, ed, enq;
            logic [1:0] e;
            upd_t       u;
            eg  = lookup_req && !(mq == QDEPTH || (mq != 0 && mst == STARVE_MAX));
            ed  = (mq != 0) && !eg;
            enq = upd_req && (mq < QDEPTH);
            n_checks++;
            if (lookup_gnt !== eg) begin n_fail++; $display("FAIL arb_gnt: got %b expected %b at %0t", lookup_gnt, eg, $time); end
            n_checks++;
            if (bht_we !== ed) begin n_fail++; $display("FAIL arb_drain: bht_we got %b expected %b at %0t", bht_we, ed, $time); end
            n_checks++;
            if (q_count !== CNT_W'(mq)) begin n_fail++; $display("FAIL q_count: got %0d expected %0d at %0t", q_count, mq, $time); end
            n_checks++;
            if (upd_ready !== (mq < QDEPTH)) begin n_fail++; $display("FAIL upd_ready: got %b expected %b at %0t", upd_ready, (mq < QDEPTH), $time); end
            n_checks++;
            if (lookup_valid !== prev_gnt) begin n_fail++; $display("FAIL lookup_valid: got %b expected %b at %0t", lookup_valid, prev_gnt, $time); end
            if (lookup_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL sb_lookup: valid with no expected entry (got %b) at %0t", lookup_cnt, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (lookup_cnt !== e) begin n_fail++; $display("FAIL sb_lookup_cnt: got %b expected %b at %0t", lookup_cnt, e, $time); end
                end
            end
            if (ed) begin
                n_checks++;
                if (upd_q.size() == 0) begin
                    n_fail++; $display("FAIL sb_drain: no queued update expected at %0t", $time);
                end else begin
                    u = upd_q.pop_front();
                    if (!(bht_en === 1'b1 && bht_addr === u.idx && bht_wdata === u.cnt)) begin
                        n_fail++;
                        $display("FAIL sb_drain: got en=%b addr=%0d data=%b expected addr=%0d data=%b at %0t",
                                 bht_en, bht_addr, bht_wdata, u.idx, u.cnt, $time);
                    end
                end
            end
            if (eg) begin
                n_checks++;
                if (!(bht_en === 1'b1 && bht_we === 1'b0 && bht_addr === lookup_idx)) begin
                    n_fail++; $display("FAIL lookup_read: got en=%b we=%b addr=%0d expected addr=%0d at %0t", bht_en, bht_we, bht_addr, lookup_idx, $time);
                end
                e = (enq && upd_idx == lookup_idx) ? upd_cnt : arch[lookup_idx];
                exp_q.push_back(e);
            end
            if (enq) begin
                u.idx = upd_idx;
                u.cnt = upd_cnt;
                upd_q.push_back(u);
                arch[upd_idx] = upd_cnt;
            end
            if (ed || mq == 0) mst = 0;
            else if (eg)       mst = mst + 1;
            mq = mq + (enq ? 1 : 0) - (ed ? 1 : 0);
            prev_gnt = (lookup_gnt === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        lookup_req = 1'b0;
        upd_req    = 1'b0;
        repeat (n) tick();
    endtask

    task automatic reset_model();
        mon_en   = 1'b0;
        upd_q.delete();
        exp_q.delete();
        mq       = 0;
        mst      = 0;
        prev_gnt = 1'b0;
        for (int i = 0; i < 64; i++) arch[i] = 2'b01;
    endtask

    task automatic test_init();
        lookup_req = 1'b1; lookup_idx = 6'd3;
        upd_req    = 1'b1; upd_idx = 6'd1; upd_cnt = 2'b11;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            n_checks++;
            if (!(bht_en === 1'b1 && bht_we === 1'b1 && bht_addr === 6'(k) && bht_wdata === 2'b01)) begin
                n_fail++;
                $display("FAIL init_write: cycle %0d got en=%b we=%b addr=%0d data=%b expected addr=%0d data=01", k, bht_en, bht_we, bht_addr, bht_wdata, k);
            end
            n_checks++;
            if ({init_done, lookup_gnt, upd_ready} !== 3'b000) begin
                n_fail++; $display("FAIL init_ctrl: cycle %0d got done/gnt/ready=%b expected 000", k, {init_done, lookup_gnt, upd_ready});
            end
        end
        lookup_req = 1'b0;
        upd_req    = 1'b0;
        @(negedge clk);
        n_checks++;
        if (init_done !== 1'b1 || upd_ready !== 1'b1) begin
            n_fail++; $display("FAIL init_done: got done=%b ready=%b expected 1 1", init_done, upd_ready);
        end
        #1;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        lookup_req = 1'b0; lookup_idx = '0;
        upd_req    = 1'b0; upd_idx = '0; upd_cnt = 2'b00;
        reset_model();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bht_en, bht_we, lookup_gnt, lookup_valid, init_done, upd_ready} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {bht_en, bht_we, lookup_gnt, lookup_valid, init_done, upd_ready});
        end
        n_checks++;
        if ({bht_addr, bht_wdata, lookup_cnt, q_count} !== '0) begin
            n_fail++; $display("FAIL reset_data: got addr=%0d wdata=%b cnt=%b q=%0d expected all 0", bht_addr, bht_wdata, lookup_cnt, q_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        test_init();
    endtask

    task automatic test_lookup_basic();
        bd_addr = 6'd5; bd_data = 2'b11; bd_en = 1'b1;
        tick();
        bd_en   = 1'b0;
        arch[5] = 2'b11;
        lookup_req = 1'b1; lookup_idx = 6'd5;
        @(negedge clk);
        n_checks++;
        if (lookup_gnt !== 1'b1) begin n_fail++; $display("FAIL basic_gnt: got %b expected 1", lookup_gnt); end
        tick();
        lookup_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (lookup_valid !== 1'b1 || lookup_cnt !== 2'b11) begin
            n_fail++; $display("FAIL basic_cnt: got valid=%b cnt=%b expected 1 11", lookup_valid, lookup_cnt);
        end
        tick();
    endtask

    task automatic test_bypass();
        lookup_req = 1'b1; lookup_idx = 6'd9;
        upd_req = 1'b1; upd_idx = 6'd5; upd_cnt = 2'b00;
        tick();
        upd_cnt = 2'b10;
        tick();
        upd_req = 1'b0; lookup_idx = 6'd5;
        @(negedge clk);
        n_checks++;
        if (lookup_gnt !== 1'b1 || q_count !== 3'd2) begin
            n_fail++; $display("FAIL bypass_gnt: got gnt=%b q=%0d expected 1 2", lookup_gnt, q_count);
        end
        tick();
        lookup_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (lookup_valid !== 1'b1 || lookup_cnt !== 2'b10) begin
            n_fail++; $display("FAIL bypass_cnt: got valid=%b cnt=%b expected 1 10", lookup_valid, lookup_cnt);
        end
        tick();
        idle(4);
        lookup_req = 1'b1; lookup_idx = 6'd5;
        tick();
        lookup_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (lookup_valid !== 1'b1 || lookup_cnt !== 2'b10) begin
            n_fail++; $display("FAIL post_drain_cnt: got valid=%b cnt=%b expected 1 10", lookup_valid, lookup_cnt);
        end
        tick();
    endtask

    task automatic test_starve();
        int grants;
        bit drained;
        idle(2);
        lookup_req = 1'b1; lookup_idx = 6'd3;
        upd_req = 1'b1; upd_idx = 6'd7; upd_cnt = 2'b11;
        tick();
        upd_req = 1'b0;
        grants  = 0;
        drained = 1'b0;
        for (int c = 0; c < 20 && !drained; c++) begin
            @(negedge clk);
            if (bht_we === 1'b1)          drained = 1'b1;
            else if (lookup_gnt === 1'b1) grants++;
            tick();
        end
        n_checks++;
        if (!drained || grants != STARVE_MAX) begin
            n_fail++; $display("FAIL starve_grants: got drained=%b grants=%0d expected 1 %0d", drained, grants, STARVE_MAX);
        end
        @(negedge clk);
        n_checks++;
        if (lookup_gnt !== 1'b1) begin n_fail++; $display("FAIL starve_resume: got gnt=%b expected 1", lookup_gnt); end
        tick();
        idle(1);
    endtask

    task automatic test_full();
        int k;
        bit saw_block;
        idle(2);
        lookup_req = 1'b1; lookup_idx = 6'd20;
        upd_req = 1'b1;
        k = 0;
        saw_block = 1'b0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            upd_idx = 6'(10 + k);
            upd_cnt = 2'(k);
            @(negedge clk);
            if (q_count === 3'd4) begin
                saw_block = 1'b1;
                n_checks++;
                if (upd_ready !== 1'b0 || lookup_gnt !== 1'b0 || bht_we !== 1'b1) begin
                    n_fail++; $display("FAIL full_block: got ready=%b gnt=%b we=%b expected 0 0 1", upd_ready, lookup_gnt, bht_we);
                end
            end
            if (upd_ready === 1'b1) k++;
            tick();
        end
        upd_req = 1'b0;
        n_checks++;
        if (!saw_block || k != 5) begin
            n_fail++; $display("FAIL full_seen: got block=%b accepted=%0d expected 1 5", saw_block, k);
        end
        idle(8);
    endtask

    task automatic test_reset_midrun();
        idle(2);
        lookup_req = 1'b1; lookup_idx = 6'd30;
        upd_req = 1'b1; upd_cnt = 2'b00;
        for (int k = 0; k < 3; k++) begin
            upd_idx = 6'(40 + k);
            tick();
        end
        upd_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (q_count !== 3'd3) begin n_fail++; $display("FAIL midrun_q3: got %0d expected 3", q_count); end
        #2;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (q_count !== 3'd0 || init_done !== 1'b0 || bht_en !== 1'b0 || lookup_gnt !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset: got q=%0d done=%b en=%b gnt=%b expected 0 0 0 0", q_count, init_done, bht_en, lookup_gnt);
        end
        reset_model();
        lookup_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        test_init();
        lookup_req = 1'b1; lookup_idx = 6'd40;
        tick();
        lookup_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (lookup_valid !== 1'b1 || lookup_cnt !== 2'b01) begin
            n_fail++; $display("FAIL discard_cnt: got valid=%b cnt=%b expected 1 01", lookup_valid, lookup_cnt);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lookup_basic();
        test_bypass();
        test_starve();
        test_full();
        test_reset_midrun();
        idle(3);
        mon_en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0 || upd_q.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: got lookups=%0d updates=%0d expected 0 0", exp_q.size(), upd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bht_port_arbiter.md
BHT_PORT_ARBITER -- requirements
Module: bht_port_arbiter

Interface
REQ-001 Parameter IDX_W, default 6, meaning BHT index width (64 entries).
REQ-002 Parameter QDEPTH, default 4, meaning update-queue depth (power of two).
REQ-003 Parameter STARVE_MAX, default 8, meaning max consecutive lookup grants while the queue is non-empty.
REQ-004 Port clk  input  1  the single clock; all state on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port lookup_req  input  1  fetch-stage prediction request.
REQ-007 Port lookup_idx  input  IDX_W  BHT index (pc[IDX_W+1:2]).
REQ-008 Port lookup_gnt  output  1  lookup accepted this cycle.
REQ-009 Port lookup_valid  output  1  lookup_cnt valid, one cycle after grant.
REQ-010 Port lookup_cnt  output  2  2-bit prediction counter.
REQ-011 Port upd_req  input  1  update request from the branch controller.
REQ-012 Port upd_idx  input  IDX_W  index to update.
REQ-013 Port upd_cnt  input  2  new counter value.
REQ-014 Port upd_ready  output  1  queue can accept an update.
REQ-015 Port bht_en  output  1  SRAM port enable.
REQ-016 Port bht_we  output  1  SRAM write enable.
REQ-017 Port bht_addr  output  IDX_W  SRAM address.
REQ-018 Port bht_wdata  output  2  SRAM write data.
REQ-019 Port bht_rdata  input  2  SRAM read data, one-cycle latency.
REQ-020 Port init_done  output  1  table initialisation complete.
REQ-021 Port q_count  output  $clog2(QDEPTH)+1  queued-update occupancy.

Function
REQ-022 Sequencing FSM SHALL have states INIT and RUN; INIT is entered on reset and moves to RUN after the write to entry 2^IDX_W-1.
REQ-023 In INIT, one entry per cycle SHALL be written with 2'b01 (WNT), from index 0 upward; lookup_gnt=0, upd_ready=0, init_done=0.
REQ-024 In RUN, init_done=1 and the single SRAM port SHALL serve at most one operation per cycle: a lookup read or a queue-drain write.
REQ-025 An update SHALL be enqueued when upd_req && upd_ready; upd_ready = (q_count < QDEPTH) in RUN.
REQ-026 Drain SHALL write the head entry (bht_we=1, bht_addr/bht_wdata from head) and pop it in the same cycle.
REQ-027 Priority: a lookup SHALL win unless (a) the queue is full or (b) the starvation counter equals STARVE_MAX; in those cases drain wins and lookup_gnt=0.
REQ-028 The starvation counter SHALL increment on each lookup grant while the queue is non-empty, and clear on a drain or when the queue is empty.
REQ-029 With no lookup_req and a non-empty queue, drain SHALL occur.
REQ-030 lookup_valid SHALL assert exactly one cycle after lookup_gnt.
REQ-031 lookup_cnt SHALL equal the youngest queued upd_cnt for lookup_idx, sampled at grant (including an update enqueued in the grant cycle); otherwise bht_rdata.
REQ-032 Simultaneous enqueue and drain SHALL leave q_count unchanged; pointers wrap modulo QDEPTH.
REQ-033 Updates to the same index SHALL drain in arrival order, with no coalescing.
REQ-034 An upd_req while upd_ready=0 SHALL be ignored; the requester holds it.

Reset
REQ-035 Asserting rst SHALL immediately clear the queue, pointers, starvation counter and pipeline valid, and force INIT with sweep index 0; all outputs SHALL be 0.
REQ-036 Reset asserted mid-INIT or mid-RUN SHALL discard pending updates and restart the sweep from index 0.

Structure
REQ-037 Package bht_pkg SHALL hold IDX_W, QDEPTH and STARVE_MAX defaults, the counter encodings SNT=00, WNT=01, WT=10, ST=11, and the INIT/RUN enum.
REQ-038 The update queue SHALL be one sub-module, bht_upd_fifo, exposing entries for the bypass compare.

Verification
REQ-039 Release reset -> 64 consecutive writes of 01 to addresses 0..63, then init_done=1 at cycle 65.
REQ-040 Lookup idx 5 with an empty queue, rdata=11 -> lookup_gnt in cycle N, lookup_valid and lookup_cnt=11 in cycle N+1.
REQ-041 Enqueue (idx 5, 00) then (idx 5, 10), then look up idx 5 before drain -> lookup_cnt=10 regardless of rdata.
REQ-042 Continuous lookup_req with one queued update -> 8 grants, a drain write in cycle 9, then grants resume.
REQ-043 Fill the queue with 4 updates under continuous lookups -> upd_ready=0, lookup_gnt=0, drain cycles until q_count<4.
REQ-044 Assert rst with q_count=3 mid-RUN -> q_count=0, init_done=0, and the sweep restarts at address 0.
